qmac_seq: RTL and testbench
===========================

# qmac_seq

Dot-product sequencer for the Q-format multiply-accumulate datapath. It accepts a job of `len` element pairs over a valid/ready stream and multiplies each pair as signed fixed-point. It accumulates the products into a 2N-bit accumulator, then presents the final sum with a sticky overflow flag on a valid/ready result port. It sits between the neuron's operand fetch logic and the activation (CORDIC) stage, which it feeds one dot product per job.

## Interface

- `Q`, 5, fractional bits of each operand (result carries 2Q fractional bits)
- `N`, 8, operand width in bits, two's complement
- `LEN_W`, 8, width of the job length field
- `clk` input 1 — sole clock, rising edge
- `reset` input 1 — asynchronous, active-low reset
- `start` input 1 — job request, sampled only in IDLE
- `len` input LEN_W — number of element pairs, sampled with `start`
- `busy` output 1 — high in RUN and DONE
- `in_valid` input 1 — operand pair valid
- `in_ready` output 1 — operand pair accepted when both high
- `in_a`, `in_b` input N each — signed Q-format operands
- `out_valid` output 1 — result valid
- `out_ready` input 1 — result consumed when both high
- `out_result` output 2N — signed accumulator, 2Q fractional bits
- `out_overflow` output 1 — sticky: accumulation overflowed during this job

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 and `len`≠0: clear the accumulator, clear overflow, load the remaining counter with `len`, go to RUN.
  - `start`=1 and `len`=0: clear the accumulator and overflow, go directly to DONE with result 0.
- RUN:
  - `in_ready`=1.
  - Each beat (`in_valid`&`in_ready`): product = signed(`in_a`)×signed(`in_b`), a full 2N-bit value that never overflows.
  - The accumulator becomes accumulator + product in 2N bits, and the counter decrements.
  - The beat that brings the counter to 0 moves the block to DONE.
- DONE: `out_valid`=1. `out_result` and `out_overflow` are held stable until `out_ready`=1, then the block goes to IDLE.
- Overflow detection: both addends have the same sign and the sum has a different sign. This sets `out_overflow`, which stays set until the next accepted `start`.
- `start` outside IDLE is ignored; it is not queued. `start` in the same cycle as the DONE handshake is also ignored.
- `in_valid` outside RUN is ignored, and no beat is consumed.
- `len` is ignored except in the cycle `start` is accepted.

## Timing

- Reset (async assert, any state):
  - state←IDLE, accumulator←0, counter←0, overflow←0.
  - `busy`=0, `in_ready`=0, `out_valid`=0, `out_result`=0, `out_overflow`=0.
  - A job in progress is discarded.
- Release of reset is synchronous to `clk`. The first `start` is accepted on the first rising edge after deassertion.
- `start` accepted at edge k: RUN from k; `in_ready`=1 in the cycle after k.
- One beat per cycle maximum. A job of L beats with no stalls occupies L cycles in RUN.
- Result latency: `out_valid`=1 in the cycle after the final beat's edge, and it already includes the last product.
- Minimum job period is L+2 cycles: start, L beats, one result cycle with `out_ready` tied high.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Configuration

- `QMAC_SAT_EN`:
  - Defined: on overflow, the accumulator clamps to the most positive value (0x7FFF for N=8) or the most negative value (0x8000), according to the sign of the addends. `out_overflow` is set as normal. Later beats continue from the clamped value.
  - Undefined: the accumulator wraps modulo 2^(2N). `out_overflow` behaves identically.

## Test plan

- Reset mid-RUN after 2 of 4 beats → all outputs 0 immediately, state IDLE. A new job with len=1 of (32,32) → `out_result`=0x0400, `out_overflow`=0.
- len=3 beats (32,32),(32,−32),(127,127) back-to-back → `out_valid` one cycle after the 3rd beat, `out_result`=0x3F01, `out_overflow`=0.
- len=3, three beats of (127,127):
  - Without `QMAC_SAT_EN`: `out_result`=0xBD03, `out_overflow`=1.
  - With `QMAC_SAT_EN`: `out_result`=0x7FFF, `out_overflow`=1.
- len=0 `start` → `out_valid`=1 next cycle, `out_result`=0, `in_ready` never high.
- Backpressure:
  - `in_valid` toggled randomly over a len=4 job (−128,−128)×4 → 0x4000×4 overflows. Check `out_overflow`=1 and `out_result`=0x0000 (wrap) or 0x7FFF (sat).
  - `out_ready` held low 5 cycles → result stable, `start` pulses ignored, `in_valid` beats ignored.
- DONE handshake with `start`=1 in the same cycle → IDLE next cycle, no job started. A second `start` is accepted, with `out_overflow` cleared from the prior job.

Source files
------------

// File: rtl/qmac_seq.sv
// Dot-product sequencer: accumulates len signed QN products into a 2N-bit sum with a sticky overflow flag.
// Optional QMAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module qmac_seq #(
  parameter int Q     = 5,
  parameter int N     = 8,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_a,
  input  logic [N-1:0]       in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     out_result,
  output logic               out_overflow
);

  localparam int AW = 2 * N;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  // Fractional bits must leave room for a sign bit in each operand.
  if (Q >= N) begin : g_q_range
    $error("qmac_seq: Q must be smaller than N");
  end

  logic [1:0]             state;
  logic signed [AW-1:0]   acc, prod, sum, acc_nxt;
  logic [LEN_W-1:0]       cnt;
  logic                   ovf, add_ovf, beat;

  assign beat    = (state == S_RUN) && in_valid;
  // N x N signed product fits exactly in 2N bits.
  assign prod    = $signed(in_a) * $signed(in_b);
  assign sum     = acc + prod;
  assign add_ovf = (acc[AW-1] == prod[AW-1]) && (sum[AW-1] != acc[AW-1]);

`ifdef QMAC_SAT_EN
  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  assign acc_nxt = add_ovf ? (acc[AW-1] ? ACC_MIN : ACC_MAX) : sum;
`else
  assign acc_nxt = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          acc   <= '0;
          ovf   <= 1'b0;
          cnt   <= len;
          state <= (len == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (beat) begin
          acc <= acc_nxt;
          ovf <= ovf | add_ovf;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (state != S_IDLE);
  assign in_ready     = (state == S_RUN);
  assign out_valid    = (state == S_DONE);
  assign out_result   = acc;
  assign out_overflow = ovf;

endmodule

// File: tb/tb_qmac_seq.sv
// Randomized + directed bench for qmac_seq against an integer-arithmetic job model.
module tb_qmac_seq;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  len = '0, in_a = '0, in_b = '0;
  logic        busy, in_ready, out_valid, out_overflow;
  logic [15:0] out_result;
  int checks = 0, errors = 0;

  // model: 0 idle, 1 consuming beats, 2 holding result
  int     m_phase = 0, m_rem = 0;
  longint m_acc = 0, m_s = 0;
  bit     m_ovf = 1'b0;
  logic [15:0] m_res;
  assign m_res = m_acc[15:0];

  qmac_seq #(.Q(5), .N(8), .LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_rem = 0; m_acc = 0; m_ovf = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_acc = 0; m_ovf = 1'b0; m_rem = int'(len);
          m_phase = (len == 0) ? 2 : 1;
        end
        1: if (in_valid) begin
          m_s = m_acc + longint'($signed(in_a)) * longint'($signed(in_b));
          if (m_s > 32767 || m_s < -32768) begin
            m_ovf = 1'b1;
`ifdef QMAC_SAT_EN
            m_s = (m_s > 0) ? 32767 : -32768;
`else
            m_s = (m_s > 0) ? m_s - 65536 : m_s + 65536;
`endif
          end
          m_acc = m_s;
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    if (!reset || m_phase == 2) begin
      chk("out_result", 32'(out_result), !reset ? 32'd0 : 32'(m_res));
      chk("out_overflow", 32'(out_overflow), !reset ? 32'd0 : 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int l);
    start = 1'b1; len = 8'(l);
    tick();
    start = 1'b0; len = 8'($urandom);
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int maxgap);
    repeat ($urandom_range(0, maxgap)) begin
      in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
    end
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // hold result for 'hold' cycles while throwing ignored start/in_valid noise at it
  task automatic take_result(input int hold);
    wait_valid();
    repeat (hold) begin
      start = 1'($urandom); len = 8'($urandom);
      in_valid = 1'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      tick();
    end
    start = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pin(input string nm, input logic [15:0] res, input logic ov);
    chk({nm, "_dut"}, 32'(out_result), 32'(res));
    chk({nm, "_dut_ovf"}, 32'(out_overflow), 32'(ov));
    chk({nm, "_model"}, 32'(m_res), 32'(res));
    chk({nm, "_model_ovf"}, 32'(m_ovf), 32'(ov));
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);

    // reset in the middle of a job
    start_job(4);
    feed(8'd32, 8'd32, 0);
    feed(8'd32, 8'd32, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(out_result), 32'd0);
    chk("midrst_ovf", 32'(out_overflow), 32'd0);
    tick();
    reset = 1'b1;
    start_job(1);
    feed(8'd32, 8'd32, 0);
    chk("len1_latency", 32'(out_valid), 32'd1);
    pin("len1", 16'h0400, 1'b0);
    take_result(0);

    start_job(3);
    feed(8'd32, 8'd32, 0);
    feed(8'd32, 8'hE0, 0);
    feed(8'd127, 8'd127, 0);
    chk("len3_latency", 32'(out_valid), 32'd1);
    pin("len3", 16'h3F01, 1'b0);
    take_result(0);

    start_job(3);
    repeat (3) feed(8'd127, 8'd127, 0);
`ifdef QMAC_SAT_EN
    pin("ovf3", 16'h7FFF, 1'b1);
`else
    pin("ovf3", 16'hBD03, 1'b1);
`endif
    take_result(1);

    start_job(0);
    chk("len0_valid", 32'(out_valid), 32'd1);
    pin("len0", 16'h0000, 1'b0);
    take_result(0);

    start_job(4);
    repeat (4) feed(8'h80, 8'h80, 3);
    wait_valid();
`ifdef QMAC_SAT_EN
    pin("neg4", 16'h7FFF, 1'b1);
`else
    pin("neg4", 16'h0000, 1'b1);
`endif
    take_result(5);

    // DONE handshake coinciding with start: start must be dropped
    start_job(3);
    repeat (3) feed(8'd127, 8'd127, 1);
    wait_valid();
    out_ready = 1'b1; start = 1'b1; len = 8'd2;
    tick();
    out_ready = 1'b0; start = 1'b0;
    chk("hs_start_busy", 32'(busy), 32'd0);
    tick();
    chk("hs_start_idle", 32'(busy), 32'd0);
    start_job(1);
    feed(8'd1, 8'd1, 0);
    pin("after_hs", 16'h0001, 1'b0);
    take_result(0);

    for (int j = 0; j < 40; j++) begin
      int l = $urandom_range(0, 6);
      repeat ($urandom_range(0, 2)) tick();
      start_job(l);
      for (int k = 0; k < l; k++) feed(8'($urandom), 8'($urandom), 2);
      take_result($urandom_range(0, 3));
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
